// File: rtl/alu_sequencer.sv
// Two-requester command sequencer that drives an external combinational ALU.
// Define ALU_SEQ_ROUND_ROBIN_EN for round-robin arbitration (fixed priority, req0 first, otherwise).
`ifndef NOP
`define NOP 8'h00
`define ADD 8'h01
`define SUB 8'h02
`define AND 8'h03
`define OR  8'h04
`define XOR 8'h05
`define RR  8'h06
`define RL  8'h07
`define INC 8'h08
`define DEC 8'h09
`define JMP 8'h0A
`define JMA 8'h0B
`define CLL 8'h0C
`define RET 8'h0D
`define ST  8'h0E
`endif

module alu_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [7:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [3:0]       req0_cnt,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [7:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [3:0]       req1_cnt,
  output logic [7:0]       alu_op,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  input  logic [WIDTH-1:0] alu_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_nxt;
  logic [7:0]       op_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       iter;
  logic             id_q;
  logic             grant0, grant1;
  logic             accept, sel;
  logic [3:0]       cnt_sel;

  function automatic logic is_iter(input logic [7:0] op);
    return (op == `RR) || (op == `RL) || (op == `INC) || (op == `DEC);
  endfunction

  function automatic logic is_ctrl(input logic [7:0] op);
    return (op == `JMP) || (op == `JMA) || (op == `CLL) ||
           (op == `RET) || (op == `ST)  || (op == `NOP);
  endfunction

`ifdef ALU_SEQ_ROUND_ROBIN_EN
  // last_id holds the requester granted most recently; reset value 1 favours req0.
  logic last_id;

  assign grant0 = req0_valid & (~req1_valid | last_id);
  assign grant1 = req1_valid & (~req0_valid | ~last_id);

  always_ff @(posedge clk) begin
    if (rst)
      last_id <= 1'b1;
    else if (accept)
      last_id <= sel;
  end
`else
  assign grant0 = req0_valid;
  assign grant1 = req1_valid & ~req0_valid;
`endif

  assign req0_ready = (state == IDLE) & grant0;
  assign req1_ready = (state == IDLE) & grant1;
  assign accept     = req0_ready | req1_ready;
  assign sel        = req1_ready;
  assign cnt_sel    = sel ? req1_cnt : req0_cnt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXEC;
      EXEC:    if (!is_iter(op_q) || (iter <= 4'd1)) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      iter  <= '0;
      id_q  <= 1'b0;
      op_q  <= `NOP;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (accept) begin
          op_q <= sel ? req1_op : req0_op;
          acc  <= sel ? req1_a : req0_a;
          id_q <= sel;
          iter <= (cnt_sel == 4'd0) ? 4'd1 : cnt_sel;
        end
        EXEC: begin
          iter <= iter - 4'd1;
          if (!is_ctrl(op_q))
            acc <= alu_out;
        end
        default: ;
      endcase
    end
  end

  // Operand B is only visible on alu_in2 during EXEC, so it needs no reset.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && accept)
      b_q <= sel ? req1_b : req0_b;
  end

  assign alu_op    = (state == EXEC) ? op_q : `NOP;
  assign alu_in1   = (state == EXEC) ? acc  : '0;
  assign alu_in2   = (state == EXEC) ? b_q  : '0;
  assign rsp_valid = (state == RESP);
  assign rsp_data  = acc;
  assign rsp_id    = id_q;
  assign busy      = (state != IDLE);

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, datapath width of operands, ALU ports and result.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports req0_valid/req1_valid  input  1  command offered by requester 0/1.
REQ-005 SHALL have ports req0_ready/req1_ready  output  1  command accepted this cycle.
REQ-006 SHALL have ports req0_op/req1_op  input  8  opcode, encoded with the codebase instruction macros (`ADD, `RR, ...).
REQ-007 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  WIDTH  operands A and B.
REQ-008 SHALL have ports req0_cnt/req1_cnt  input  4  repeat count for iterative ops.
REQ-009 SHALL have port alu_op  output  8  opcode driven to the ALU.
REQ-010 SHALL have ports alu_in1, alu_in2  output  WIDTH  ALU operands.
REQ-011 SHALL have port alu_out  input  WIDTH  combinational ALU result.
REQ-012 SHALL have ports rsp_valid output 1 / rsp_ready input 1  result handshake.
REQ-013 SHALL have ports rsp_data output WIDTH / rsp_id output 1  result and originating requester.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM IDLE -> EXEC -> RESP -> IDLE.
REQ-016 In IDLE: drive reqN_ready=1 combinationally for exactly the granted requester with reqN_valid=1; the other ready=0; accept on valid&ready and go to EXEC next cycle.
REQ-017 On accept: latch op, B, id; acc<=A; iter<=cnt, with cnt=0 treated as 1.
REQ-018 In EXEC: alu_op=latched op, alu_in1=acc, alu_in2=latched B; each cycle acc<=alu_out, iter<=iter-1.
REQ-019 Iterative ops (`RR, `RL, `INC, `DEC) SHALL stay in EXEC for iter cycles (1..15); all other ops SHALL take exactly 1 EXEC cycle, ignoring cnt.
REQ-020 Control opcodes (`JMP, `JMA, `CLL, `RET, `ST, `NOP) SHALL take 1 EXEC cycle and return A unchanged, without capturing alu_out.
REQ-021 Latency: accept at edge N -> rsp_valid high from edge N+1+k, k = EXEC cycles.
REQ-022 In RESP: rsp_valid=1, rsp_data=acc, rsp_id=latched id, stable until rsp_ready=1; on rsp_valid&rsp_ready return to IDLE.
REQ-023 Outside EXEC: alu_op=`NOP, alu_in1=0, alu_in2=0.
REQ-024 No new command SHALL be accepted in EXEC or RESP (both ready=0); at most one command outstanding.
REQ-025 Arithmetic wraps modulo 2^WIDTH, as produced by the ALU; sequencer adds no saturation.

Reset
REQ-026 rst SHALL force state=IDLE, acc=0, iter=0, id=0, op=`NOP, rsp_valid=0, busy=0, arbitration pointer favouring req0.
REQ-027 rst in EXEC or RESP SHALL abort the command; no response is ever issued for it.
REQ-028 rst has priority over any handshake in the same cycle.

Configuration
REQ-029 Macro ALU_SEQ_ROUND_ROBIN_EN defined: when both valid in IDLE, grant the requester not granted last; pointer updates on each accept.
REQ-030 Macro ALU_SEQ_ROUND_ROBIN_EN undefined: fixed priority, req0 always wins when both valid; no pointer state.

Verification
REQ-031 req0 `ADD a=16'h0003 b=16'h0004 -> req0_ready 1 cycle, rsp_valid 2 cycles later, rsp_data=16'h0007, rsp_id=0.
REQ-032 req1 `RL a=16'h8001 cnt=4 -> 4 EXEC cycles, rsp_data=16'h0018, rsp_id=1; cnt=0 -> 1 rotation, 16'h0003.
REQ-033 Both valid, back-to-back `INC a=0 -> with macro: grants 0,1,0,1; without: 0,0,0,0 while req0 held valid.
REQ-034 rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_data/rsp_id stable, both ready=0, alu_op=`NOP throughout.
REQ-035 `SUB a=0 b=1 -> rsp_data=16'hFFFF; `JMP a=16'h1234 -> rsp_data=16'h1234 after 1 EXEC cycle.
REQ-036 rst asserted in 2nd EXEC cycle of `DEC cnt=8 -> next cycle IDLE, busy=0, no rsp_valid; next command serviced normally.
